// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: two-core data-memory command bus (commands in, ready/stall/rdata out)
interface data_mem_responder_if #(parameter int W_CPU = 32, parameter int W_MEM_CMD = 2);
  logic [W_MEM_CMD-1:0] mem_cmd_0, mem_cmd_1;
  logic [W_CPU-1:0] addr_0, addr_1, wdata_0, wdata_1, rdata_0, rdata_1;
  logic ready_0, ready_1, stall_0, stall_1;
  modport master(output mem_cmd_0, addr_0, wdata_0, mem_cmd_1, addr_1, wdata_1,
                 input rdata_0, rdata_1, ready_0, ready_1, stall_0, stall_1);
  modport slave(input mem_cmd_0, addr_0, wdata_0, mem_cmd_1, addr_1, wdata_1,
                output rdata_0, rdata_1, ready_0, ready_1, stall_0, stall_1);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: shared word-addressed data memory serving two cores; define DATA_MEM_RR_EN for round-robin arbitration
module data_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int AW = 10,
  parameter int LAT = 2,
  parameter int W_CPU = 32
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);
  localparam logic [1:0] MEM_NOP = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2;
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_gnt, r_we, r_ready_0, r_ready_1;
  logic [AW-1:0] r_idx;
  logic [W_CPU-1:0] r_wdata, r_rdata_0, r_rdata_1;
  logic [W_CPU-1:0] r_mem [DEPTH];
  logic w_req_0, w_req_1, w_gnt, w_start, w_done, w_unused;
  assign w_req_0 = bus.mem_cmd_0 == MEM_READ || bus.mem_cmd_0 == MEM_WRITE;
  assign w_req_1 = bus.mem_cmd_1 == MEM_READ || bus.mem_cmd_1 == MEM_WRITE;
  assign w_unused = ^{bus.addr_0[1:0], bus.addr_0[W_CPU-1:AW+2], bus.addr_1[1:0], bus.addr_1[W_CPU-1:AW+2], MEM_NOP};
`ifdef DATA_MEM_RR_EN
  logic r_ptr;
  assign w_gnt = (w_req_0 && w_req_1) ? r_ptr : w_req_1;
  // prefer the core that was not just granted
  always_ff @(posedge clk)
    if (rst) r_ptr <= 1'b0;
    else if (w_start) r_ptr <= ~w_gnt;
`else
  assign w_gnt = !w_req_0 && w_req_1;
`endif
  // next state: IDLE samples requests, ACCESS counts down, RESPOND lasts one cycle
  always_comb begin
    w_start = r_state == IDLE && (w_req_0 || w_req_1);
    w_done = r_state == ACCESS && r_cnt == 4'd0;
    w_next = w_start ? ACCESS : w_done ? RESPOND : r_state == RESPOND ? IDLE : r_state;
  end
  // state register and latency counter
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_start ? 4'(LAT - 1) : (r_state == ACCESS && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
    end
  // latch the granted request; the core holds it anyway, but this frees the core's pins
  always_ff @(posedge clk)
    if (w_start) begin
      r_gnt <= w_gnt;
      r_we <= (w_gnt ? bus.mem_cmd_1 : bus.mem_cmd_0) == MEM_WRITE;
      r_idx <= w_gnt ? bus.addr_1[AW+1:2] : bus.addr_0[AW+1:2];
      r_wdata <= w_gnt ? bus.wdata_1 : bus.wdata_0;
    end
  // commit writes at the end of ACCESS unless reset aborts the access
  always_ff @(posedge clk)
    if (!rst && w_done && r_we) r_mem[r_idx] <= r_wdata;
  // registered completion pulse and per-core read data
  always_ff @(posedge clk)
    if (rst) begin
      r_ready_0 <= 1'b0;
      r_ready_1 <= 1'b0;
      r_rdata_0 <= '0;
      r_rdata_1 <= '0;
    end else begin
      r_ready_0 <= w_done && !r_gnt;
      r_ready_1 <= w_done && r_gnt;
      if (w_done && !r_we && !r_gnt) r_rdata_0 <= r_mem[r_idx];
      if (w_done && !r_we && r_gnt) r_rdata_1 <= r_mem[r_idx];
    end
  assign bus.ready_0 = r_ready_0;
  assign bus.ready_1 = r_ready_1;
  assign bus.rdata_0 = r_rdata_0;
  assign bus.rdata_1 = r_rdata_1;
  assign bus.stall_0 = w_req_0 && !r_ready_0;
  assign bus.stall_1 = w_req_1 && !r_ready_1;
endmodule
